// File: rtl/uart_rx_ctrl.sv
`timescale 1ns/1ps
// UART receive sequencer: oversampled start/data/parity/stop framing with a byte hand-off.
// Latency: data_valid rises floor(D/2)+(DATA_BITS+2)*D+1 cycles after the first idle cycle that sees rx low.
// Backpressure: the byte is held until data_valid & data_ready; a frame completing while held is dropped (overrun pulse).
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   rx                - asynchronous serial input, idles high
//   baud_div          - clocks per bit (min 4 enforced), latched at start detection
//   data_out/_valid   - received byte and its valid, consumed with data_ready
//   parity_err        - parity mismatch for the held byte
//   frame_err         - stop bit was low for the held byte
//   overrun           - one-cycle pulse when a completed frame is dropped
//   busy              - frame sequencer is not idle
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0,
  parameter int DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state_q;
  logic                 sync1_q, rxs_q;
  logic [1:0]           sync_vld_q;
  logic                 armed_q;
  logic [DIV_W-1:0]     div_q, cnt_q;
  logic [IDX_W-1:0]     bit_idx_q;
  logic [DATA_BITS-1:0] shift_q, dout_q;
  logic                 perr_q, dvld_q, perr_out_q, ferr_q, ovr_q;

  logic [DIV_W-1:0]     div_d, half_m1_d, cnt_inc_d;
  logic                 rxs, bit_end, accept, stop_done, perr_d;

  assign rxs       = rxs_q;
  assign div_d     = (baud_div < DIV_W'(4)) ? DIV_W'(4) : baud_div;
  assign half_m1_d = (div_q >> 1) - DIV_W'(1);
  assign cnt_inc_d = cnt_q + DIV_W'(1);
  assign bit_end   = (cnt_q == div_q - DIV_W'(1));
  assign accept    = dvld_q & data_ready;
  assign stop_done = (state_q == S_STOP) && bit_end;
  // Mismatch when data XOR parity bit differs from the configured sense.
  assign perr_d    = (^shift_q) ^ rxs ^ PARITY_ODD;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sync1_q    <= 1'b1;
      rxs_q      <= 1'b1;
      sync_vld_q <= 2'b00;
      armed_q    <= 1'b0;
      div_q      <= '0;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      dout_q     <= '0;
      dvld_q     <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rxs_q      <= sync1_q;
      // The synchronizer's reset value is not a real line sample; only arm
      // once a high has actually propagated from rx.
      sync_vld_q <= {sync_vld_q[0], 1'b1};
      if (sync_vld_q[1] && rxs) armed_q <= 1'b1;

      ovr_q <= 1'b0;
      if (accept) begin
        dvld_q     <= 1'b0;
        perr_out_q <= 1'b0;
        ferr_q     <= 1'b0;
      end
      // An accept in the completion cycle frees the slot for the new byte.
      if (stop_done) begin
        if (!dvld_q || accept) begin
          dout_q     <= shift_q;
          dvld_q     <= 1'b1;
          perr_out_q <= perr_q;
          ferr_q     <= ~rxs;
        end else begin
          ovr_q <= 1'b1;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (armed_q && !rxs) begin
            state_q <= S_START;
            cnt_q   <= '0;
            div_q   <= div_d;
          end
        end
        S_START: begin
          if (cnt_q == half_m1_d) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q              <= '0;
            shift_q[bit_idx_q] <= rxs;
            if (bit_idx_q == IDX_W'(DATA_BITS - 1)) state_q <= S_PARITY;
            else bit_idx_q <= bit_idx_q + IDX_W'(1);
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            perr_q  <= perr_d;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= rxs ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt_q <= cnt_inc_d;
          end
        end
        S_WAIT_HIGH: begin
          // Line stuck low (break): hold off retrigger until it returns high.
          if (rxs) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvld_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
`timescale 1ns/1ps
// Bench for uart_rx_ctrl: table of frames plus hand-written corner sequences,
// with a scoreboard of expected bytes checked when the DUT presents them.
module tb_uart_rx_ctrl;

  logic        clk, rst, rx, data_ready;
  logic [15:0] baud_div;
  logic [7:0]  data_out;
  logic        data_valid, parity_err, frame_err, overrun, busy;

  uart_rx_ctrl dut (
    .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
    logic        par;
    logic        stp;
    logic [7:0]  exp_d;
    logic        exp_pe;
    logic        exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         ecyc;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   ovr_cnt = 0;
  logic prev_vld = 1'b0;
  logic prev_acc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: a new byte is on the bus when valid rises or stays
  // high straight after a handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_vld = 1'b0;
      prev_acc = 1'b0;
    end else begin
      if (overrun) ovr_cnt++;
      if (data_valid && (!prev_vld || prev_acc)) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_unexpected: got byte 0x%0h, want no byte", data_out);
        end else begin
          e = sb_q.pop_front();
          check("sb_data", data_out, e.d);
          check("sb_parity_err", parity_err, e.pe);
          check("sb_frame_err", frame_err, e.fe);
          check("sb_latency_cycle", cyc, e.ecyc);
        end
      end
      prev_acc = data_valid && data_ready;
      prev_vld = data_valid;
    end
  end

  // Drives one frame; rx is left at the stop-bit value on return.
  task automatic send_frame(input logic [15:0] div, input logic [7:0] d, input logic par,
                            input logic stp, input bit push, input logic [7:0] ed,
                            input logic epe, input logic efe);
    int   deff;
    int   h;
    exp_t e;
    deff = (div < 16'd4) ? 4 : int'(div);
    h = deff / 2;
    baud_div = div;
    rx = 1'b0;
    if (push) begin
      e.d = ed; e.pe = epe; e.fe = efe;
      e.ecyc = cyc + 3 + h + 10 * deff;
      sb_q.push_back(e);
    end
    repeat (deff) tick();
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (deff) tick();
    end
    rx = par;
    repeat (deff) tick();
    rx = stp;
    repeat (deff) tick();
  endtask

  task automatic wait_valid(input string nm);
    int n;
    n = 0;
    while (!data_valid && n < 400) begin
      tick();
      n++;
    end
    check(nm, data_valid, 1'b1);
  endtask

  task automatic accept_byte(input string nm);
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    check({nm, "_valid_clear"}, data_valid, 1'b0);
    check({nm, "_flags_clear"}, {parity_err, frame_err}, 2'b00);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int ovr0;
    int cnt;
    int h;

    vecs[0] = '{16'd16, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{16'd16, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{16'd16, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
    vecs[3] = '{16'd8,  8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0};
    vecs[4] = '{16'd5,  8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{16'd2,  8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[6] = '{16'd3,  8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1};

    rst = 1'b1; rx = 1'b1; data_ready = 1'b0; baud_div = 16'd16;
    repeat (3) tick();
    check("rst_data_out", data_out, 8'h00);
    check("rst_valid", data_valid, 1'b0);
    check("rst_flags", {parity_err, frame_err, overrun}, 3'b000);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) tick();

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].div, vecs[i].data, vecs[i].par, vecs[i].stp, 1'b1,
                 vecs[i].exp_d, vecs[i].exp_pe, vecs[i].exp_fe);
      rx = 1'b1;
      wait_valid("vec_valid");
      repeat (3) tick();
      check("vec_hold_valid", data_valid, 1'b1);
      check("vec_data", data_out, vecs[i].exp_d);
      check("vec_parity_err", parity_err, vecs[i].exp_pe);
      check("vec_frame_err", frame_err, vecs[i].exp_fe);
      accept_byte("vec_accept");
      repeat (4) tick();
    end

    // Break: stop bit low, then line held low
    send_frame(16'd16, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    cnt = 0;
    repeat (100) begin
      tick();
      if (!busy) cnt++;
    end
    check("brk_busy_low_cycles", cnt, 0);
    check("brk_valid", data_valid, 1'b1);
    check("brk_frame_err", frame_err, 1'b1);
    accept_byte("brk_accept");
    repeat (20) tick();
    check("brk_still_waiting", busy, 1'b1);
    rx = 1'b1;
    repeat (4) tick();
    check("brk_released", busy, 1'b0);

    // Glitch rejection
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    cnt = 0;
    repeat (30) begin
      if (busy) cnt++;
      tick();
    end
    check("glitch_busy_pulsed", cnt > 0, 1'b1);
    check("glitch_busy_end", busy, 1'b0);
    check("glitch_valid", data_valid, 1'b0);

    // Overrun: second frame dropped while first is held
    ovr0 = ovr_cnt;
    send_frame(16'd16, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    rx = 1'b1;
    send_frame(16'd16, 8'h22, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    rx = 1'b1;
    repeat (6) tick();
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_data_kept", data_out, 8'h11);
    check("ovr_valid", data_valid, 1'b1);
    accept_byte("ovr_accept");
    repeat (4) tick();

    // Accept in the completion cycle of the next frame
    ovr0 = ovr_cnt;
    send_frame(16'd16, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
    rx = 1'b1;
    h = 8;
    fork
      send_frame(16'd16, 8'h22, 1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
      begin
        repeat (2 + h + 10 * 16) tick();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
      end
    join
    rx = 1'b1;
    repeat (6) tick();
    check("sim_no_overrun", ovr_cnt - ovr0, 0);
    check("sim_new_data", data_out, 8'h22);
    check("sim_valid", data_valid, 1'b1);
    accept_byte("sim_accept");
    repeat (4) tick();

    // Reset mid-frame with a byte held, line then kept low
    send_frame(16'd16, 8'h77, 1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    rx = 1'b1;
    wait_valid("rstm_pre_valid");
    rx = 1'b0;
    baud_div = 16'd16;
    repeat (40) tick();
    check("rstm_in_frame", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstm_data_out", data_out, 8'h00);
    check("rstm_valid", data_valid, 1'b0);
    check("rstm_flags", {parity_err, frame_err, overrun}, 3'b000);
    check("rstm_busy", busy, 1'b0);
    cnt = 0;
    repeat (50) begin
      tick();
      if (busy || data_valid) cnt++;
    end
    check("rstm_no_false_start", cnt, 0);
    rx = 1'b1;
    repeat (5) tick();
    send_frame(16'd2, 8'h5A, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
    rx = 1'b1;
    wait_valid("div2_valid");
    check("div2_data", data_out, 8'h5A);
    accept_byte("div2_accept");
    repeat (4) tick();

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
